// File: rtl/vga_score_bcd.sv
// BCD score keeper for a VGA game: serial digit-at-a-time adder plus a frame-stable display copy.
// Optional SCORE_SATURATE_EN: on overflow saturate the score at all 9s instead of wrapping.
module vga_score_bcd #(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   add_valid,
  input  logic [3:0]             add_amount,
  output logic                   add_ready,
  input  logic                   frame_start,
  output logic [4*NDIGITS-1:0]   disp_digits,
  output logic                   overflow
);

  localparam int unsigned W       = 4 * NDIGITS;
  localparam logic [2:0]  LastIdx = 3'(NDIGITS - 1);

  typedef enum logic {StIdle, StAdd} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   live_q, live_d;
  logic [W-1:0]   disp_q, disp_d;
  logic [3:0]     amount_q, amount_d;
  logic [2:0]     idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           pending_q, pending_d;
  logic           ovf_q, ovf_d;

  logic           accept;
  logic [3:0]     cur_digit;
  logic [3:0]     addend;
  logic [4:0]     sum;
  logic [4:0]     sum_adj;
  logic [3:0]     new_digit;
  logic           carry_out;

  always_comb begin
    add_ready = (state_q == StIdle) && !clear;
    accept    = add_valid && add_ready;
    cur_digit = live_q[{idx_q, 2'b00} +: 4];
    addend    = (idx_q == 3'd0) ? amount_q : 4'd0;
    sum       = {1'b0, cur_digit} + {1'b0, addend} + {4'd0, carry_q};
    sum_adj   = sum - 5'd10;
    carry_out = (sum > 5'd9);
    new_digit = carry_out ? sum_adj[3:0] : sum[3:0];
  end

  always_comb begin
    state_d   = state_q;
    live_d    = live_q;
    disp_d    = disp_q;
    amount_d  = amount_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    pending_d = pending_q;
    ovf_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          amount_d = (add_amount > 4'd9) ? 4'd9 : add_amount;
          idx_d    = 3'd0;
          carry_d  = 1'b0;
          state_d  = StAdd;
        end
      end
      StAdd: begin
        live_d[{idx_q, 2'b00} +: 4] = new_digit;
        carry_d = carry_out;
        idx_d   = idx_q + 3'd1;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          if (carry_out) begin
            ovf_d = 1'b1;
`ifdef SCORE_SATURATE_EN
            live_d = {NDIGITS{4'd9}};
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Clear wins over any add in flight but leaves the display path alone.
    if (clear) begin
      live_d  = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      state_d = StIdle;
    end

    // The copy samples live_q, so a frame coinciding with acceptance shows the pre-add score.
    if ((state_q == StIdle) && (frame_start || pending_q)) begin
      disp_d    = live_q;
      pending_d = 1'b0;
    end else if (frame_start) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      live_q    <= '0;
      disp_q    <= '0;
      amount_q  <= 4'd0;
      idx_q     <= 3'd0;
      carry_q   <= 1'b0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      disp_q    <= disp_d;
      amount_q  <= amount_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign disp_digits = disp_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/vga_score_bcd.md
VGA_SCORE_BCD -- requirements
Module: vga_score_bcd

Interface
REQ-001 SHALL have parameter NDIGITS, default 4, number of BCD score digits (1..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clear  input  1  synchronous score clear (new game).
REQ-005 SHALL have port add_valid  input  1  request to add add_amount to score.
REQ-006 SHALL have port add_amount  input  4  points to add, binary 0..15.
REQ-007 SHALL have port add_ready  output  1  adder idle; request accepted when add_valid & add_ready.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-009 SHALL have port disp_digits  output  4*NDIGITS  frame-stable BCD digits for the segment renderer; digit 0 (least significant) in bits [3:0].
REQ-010 SHALL have port overflow  output  1  one-cycle pulse when an addition exceeds 10^NDIGITS-1.

Function
REQ-011 SHALL hold live score as NDIGITS 4-bit BCD registers, each always 0..9.
REQ-012 SHALL clamp add_amount values 10..15 to 9 at acceptance.
REQ-013 SHALL implement FSM IDLE -> ADD -> IDLE; add_ready = 1 only in IDLE and when clear = 0.
REQ-014 SHALL on acceptance latch the clamped amount, set digit index 0, carry 0, enter ADD.
REQ-015 SHALL in ADD process one digit per cycle: sum = digit + (index==0 ? amount : 0) + carry; if sum > 9 then digit = sum-10, carry = 1; else digit = sum, carry = 0; index increments.
REQ-016 SHALL leave ADD after the cycle processing digit NDIGITS-1, so add_ready is low for exactly NDIGITS cycles after acceptance.
REQ-017 SHALL, when carry out of digit NDIGITS-1 is 1, pulse overflow in the cycle after that digit is processed and apply the REQ-027 behaviour.
REQ-018 SHALL, on frame_start while IDLE, copy the live score to disp_digits at that edge.
REQ-019 SHALL, on frame_start while in ADD, set a pending flag; the copy occurs on the first edge with state IDLE, then pending clears.
REQ-020 SHALL, on simultaneous frame_start and acceptance in IDLE, copy the pre-add score and start the add.
REQ-021 SHALL, on clear = 1, zero the live score, abort any add, drop carry, go to IDLE; clear has priority over add_valid; disp_digits and pending are unaffected (pending copy still happens, showing 0).
REQ-022 SHALL change disp_digits only at a frame copy or reset, never mid-frame.

Reset
REQ-023 SHALL, while reset_n = 0, asynchronously force state IDLE, live score 0, disp_digits 0, pending 0, carry 0, overflow 0.
REQ-024 SHALL drive add_ready = 1 on the first edge after reset_n deasserts.
REQ-025 SHALL treat reset_n assertion mid-ADD as a full abort; the partial sum is lost.

Configuration
REQ-026 SHALL use macro SCORE_SATURATE_EN to select overflow handling.
REQ-027 SHALL, with SCORE_SATURATE_EN defined, set all live digits to 9 on overflow; without it, keep the wrapped digits (score modulo 10^NDIGITS); overflow pulses in both cases.

Verification
REQ-028 SHALL cover: reset, add 7 then frame_start -> add_ready low 4 cycles, disp_digits = 0x0007.
REQ-029 SHALL cover: score 0099, add 5, frame_start -> disp_digits = 0x0104, no overflow.
REQ-030 SHALL cover: score 9998, add 9 -> overflow pulse once; live = 9999 with SCORE_SATURATE_EN, 0007 without.
REQ-031 SHALL cover: add_amount 15 from score 0 -> live score 0009.
REQ-032 SHALL cover: frame_start during ADD of 3 to 0040 -> disp_digits stays old until the add completes, then shows 0x0043.
REQ-033 SHALL cover: clear and add_valid asserted together at score 0123 -> add ignored, next frame shows 0x0000; reset_n pulsed mid-ADD -> all outputs 0 immediately.
